n_arbiter: RTL and testbench

//  Shares one N resource (ports A[7:0], x, y[3:0] -> z) between N_REQ requesters.

---
 rtl/n_arbiter_pkg.sv | 14 +
 rtl/n_arbiter_rr_pick.sv | 32 +++
 rtl/n_arbiter.sv | 139 +++++++++++++
 tb/tb_n_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n_arbiter_pkg.sv
// Shared types and widths for the N-resource round-robin arbiter.
package n_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int A_W = 8;
    localparam int Y_W = 4;

endpackage

// File: rtl/n_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr, wrapping.
module n_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  idx,
    output logic [N_REQ-1:0] onehot
);

    int pos;

    // Scan from farthest to nearest so the nearest valid slot after ptr wins.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        pos    = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            pos = (int'(ptr) + k) % N_REQ;
            if (valid[pos]) begin
                any         = 1'b1;
                idx         = ID_W'(pos);
                onehot      = '0;
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/n_arbiter.sv
// Time-shares one N resource between N_REQ requesters: round-robin grant,
// one outstanding transaction, fixed-latency result capture, tagged response.
module n_arbiter
    import n_arbiter_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  LATENCY = 2,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*8-1:0] req_a,
    input  logic [N_REQ*4-1:0] req_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_z,
    output logic [A_W-1:0]     res_a,
    output logic               res_x,
    output logic [Y_W-1:0]     res_y,
    input  logic               res_z
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t           state_reg, state_next;
    logic [ID_W-1:0]  ptr_reg, ptr_next;
    logic [ID_W-1:0]  id_reg, id_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [A_W-1:0]   a_reg, a_next;
    logic [Y_W-1:0]   y_reg, y_next;
    logic             z_reg, z_next;

    logic             pick_any;
    logic [ID_W-1:0]  pick_idx;
    logic [N_REQ-1:0] pick_onehot;

    logic [A_W-1:0]   a_slice [N_REQ];
    logic [Y_W-1:0]   y_slice [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_slice[gi] = req_a[gi*A_W +: A_W];
            assign y_slice[gi] = req_y[gi*Y_W +: Y_W];
        end
    endgenerate

    n_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .valid  (req_valid),
        .ptr    (ptr_reg),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= ID_W'(N_REQ - 1);
            id_reg    <= '0;
            cnt_reg   <= '0;
            a_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            id_reg    <= id_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            y_reg     <= y_next;
            z_reg     <= z_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        id_next    = id_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        y_next     = y_reg;
        z_next     = z_reg;
        req_ready  = '0;
        rsp_valid  = 1'b0;
        rsp_id     = '0;
        rsp_z      = 1'b0;
        res_a      = '0;
        res_x      = 1'b0;
        res_y      = '0;
        case (state_reg)
            IDLE: begin
                // A visible grant is always taken: ready is only raised for a valid requester.
                if (pick_any) begin
                    req_ready  = pick_onehot;
                    a_next     = a_slice[pick_idx];
                    y_next     = y_slice[pick_idx];
                    id_next    = pick_idx;
                    ptr_next   = pick_idx;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                res_x      = 1'b1;
                res_a      = a_reg;
                res_y      = y_reg;
                cnt_next   = CNT_W'(LATENCY - 1);
                state_next = WAIT;
            end
            WAIT: begin
                res_a = a_reg;
                res_y = y_reg;
                if (cnt_reg == '0) begin
                    z_next     = res_z;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RESP: begin
                res_a     = a_reg;
                res_y     = y_reg;
                rsp_valid = 1'b1;
                rsp_id    = id_reg;
                rsp_z     = z_reg;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_n_arbiter.sv
// Scoreboard bench for n_arbiter: reference grant model, fixed-latency N model,
// directed boundary scenarios followed by randomized traffic.
module tb_n_arbiter;

    localparam int N_REQ   = 4;
    localparam int LATENCY = 2;
    localparam int ID_W    = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*8-1:0] req_a;
    logic [N_REQ*4-1:0] req_y;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic               rsp_z;
    logic [7:0]         res_a;
    logic               res_x;
    logic [3:0]         res_y;
    logic               res_z = 1'b0;

    n_arbiter #(.N_REQ(N_REQ), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .res_a     (res_a),
        .res_x     (res_x),
        .res_y     (res_y),
        .res_z     (res_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [3:0] y;
        logic       z;
    } txn_t;

    txn_t sb[$];
    int   grant_log[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   grant_cycle = 0;
    int   ptr_m = N_REQ - 1;
    bit   busy = 1'b0;
    bit   rsp_seen = 1'b0;
    bit   prev_rst_low = 1'b0;

    // The resource's function; its result is only valid LATENCY cycles after x.
    function automatic logic nz(input logic [7:0] a, input logic [3:0] y);
        return ~(^a ^ ^y);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cycle);
    endtask

    // N model: x-pulse captures operands; z is correct only in cycle t0+LATENCY.
    int   n_age = 1000;
    logic n_val = 1'b0;
    always @(negedge clk) begin
        if (res_x === 1'b1) begin
            n_age = 0;
            n_val = nz(res_a, res_y);
        end else if (n_age < 1000) begin
            n_age++;
        end
        res_z = (n_age == LATENCY) ? n_val : ~n_val;
    end

    // Reference model and monitor; inputs are stable here and outputs settled.
    always @(negedge clk) begin
        logic [N_REQ-1:0] exp_rdy;
        int               win;
        bit               found;
        txn_t             t;
        cycle++;
        if (rst_n !== 1'b1) begin
            if (prev_rst_low && req_valid == '0) begin
                check("rst_req_ready", 32'(req_ready), 32'(0));
                check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
                check("rst_rsp_id", 32'(rsp_id), 32'(0));
                check("rst_rsp_z", 32'(rsp_z), 32'(0));
                check("rst_res_a", 32'(res_a), 32'(0));
                check("rst_res_x", 32'(res_x), 32'(0));
                check("rst_res_y", 32'(res_y), 32'(0));
            end
            sb.delete();
            busy         = 1'b0;
            rsp_seen     = 1'b0;
            ptr_m        = N_REQ - 1;
            prev_rst_low = 1'b1;
        end else begin
            prev_rst_low = 1'b0;
            exp_rdy = '0;
            found   = 1'b0;
            win     = 0;
            if (!busy) begin
                for (int k = 1; k <= N_REQ; k++) begin
                    if (!found && req_valid[(ptr_m + k) % N_REQ]) begin
                        found = 1'b1;
                        win   = (ptr_m + k) % N_REQ;
                    end
                end
                if (found) exp_rdy[win] = 1'b1;
            end
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("res_x", 32'(res_x), 32'(busy && cycle == grant_cycle + 1));
            if (busy) begin
                check("res_a", 32'(res_a), 32'(sb[0].a));
                check("res_y", 32'(res_y), 32'(sb[0].y));
                if (cycle == grant_cycle + LATENCY + 2)
                    check("rsp_latency", 32'(rsp_valid), 32'(1));
                if (rsp_seen)
                    check("rsp_valid_hold", 32'(rsp_valid), 32'(1));
                if (rsp_valid === 1'b1) begin
                    if (!rsp_seen)
                        check("rsp_early", 32'(cycle - grant_cycle), 32'(LATENCY + 2));
                    rsp_seen = 1'b1;
                    check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                    check("rsp_z", 32'(rsp_z), 32'(sb[0].z));
                    if (rsp_ready) begin
                        $display("txn id=%0d a=%02h y=%01h z=%0b cycle=%0d",
                                 rsp_id, sb[0].a, sb[0].y, rsp_z, cycle);
                        void'(sb.pop_front());
                        busy     = 1'b0;
                        rsp_seen = 1'b0;
                    end
                end
            end else begin
                check("res_a_idle", 32'(res_a), 32'(0));
                check("res_y_idle", 32'(res_y), 32'(0));
                check("rsp_valid_idle", 32'(rsp_valid), 32'(0));
            end
            if (found) begin
                t.id = win;
                t.a  = req_a[8*win +: 8];
                t.y  = req_y[4*win +: 4];
                t.z  = nz(t.a, t.y);
                sb.push_back(t);
                grant_log.push_back(win);
                busy        = 1'b1;
                grant_cycle = cycle;
                ptr_m       = win;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || sb.size() != 0) && n < limit) begin
            step(1);
            n++;
        end
        if (busy || sb.size() != 0) fail_now("idle_timeout");
    endtask

    task automatic wait_grants(input int cnt, input int limit);
        int n = 0;
        while (grant_log.size() < cnt && n < limit) begin
            step(1);
            n++;
        end
        if (grant_log.size() < cnt) fail_now("grant_timeout");
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        step(3);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_y     = '0;
        step(3);
        rst_n = 1'b1;

        // Single request from requester 2.
        grant_log.delete();
        req_a[23:16] = 8'hA5;
        req_y[11:8]  = 4'h3;
        req_valid    = 4'b0100;
        step(1);
        req_valid = '0;
        wait_idle(50);
        wait_grants(1, 5);
        if (grant_log.size() > 0) check("single_grant", 32'(grant_log[0]), 32'(2));

        // Fairness from reset pointer: 0,1,2,3,0.
        do_reset();
        grant_log.delete();
        req_valid = 4'b1111;
        wait_grants(5, 100);
        req_valid = '0;
        wait_idle(50);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check("fair_order", 32'(grant_log[k]), 32'(k % N_REQ));

        // Backpressure: response held, other requesters wait.
        rsp_ready = 1'b0;
        req_a[7:0] = 8'h5A;
        req_valid  = 4'b0001;
        step(1);
        req_valid = 4'b1110;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin step(1); n++; end
        if (rsp_valid !== 1'b1) fail_now("bp_rsp_timeout");
        step(5);
        grant_log.delete();
        rsp_ready = 1'b1;
        wait_grants(1, 5);
        req_valid = '0;
        wait_idle(50);

        // Operand change after handshake.
        req_a[7:0] = 8'h3C;
        req_y[3:0] = 4'h9;
        req_valid  = 4'b0001;
        step(1);
        req_valid  = '0;
        req_a[7:0] = 8'hFF;
        req_y[3:0] = 4'h0;
        wait_idle(50);

        // Reset mid-WAIT, then requester 0 must win first.
        req_valid = 4'b0010;
        step(1);
        req_valid = '0;
        step(2);
        do_reset();
        grant_log.delete();
        req_valid = 4'b1111;
        wait_grants(1, 5);
        req_valid = '0;
        if (grant_log.size() > 0) check("post_rst_grant", 32'(grant_log[0]), 32'(0));
        wait_idle(50);

        // Randomized traffic with random backpressure and dropped requests.
        for (int c = 0; c < 1500; c++) begin
            req_valid = N_REQ'($urandom);
            req_a     = ($urandom << 16) ^ $urandom;
            req_y     = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
